// File: rtl/div_request_sequencer.sv
// Request FIFO + start/settle/capture sequencer for the 4-bit divider.
// Optional: DIV_DBZ_SKIP_EN bypasses the divider for zero divisors.
module div_request_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [3:0] div_a,
    output logic [3:0] div_b,
    output logic       div_start,
    input  logic [7:0] div_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_quot,
    output logic [3:0] out_rem,
    output logic       out_dbz
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FIRE = 3'd2,
        S_WAIT = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    div_a_q, div_a_d;
    logic [3:0]    div_b_q, div_b_d;
    logic          dbz_q, dbz_d;
    logic          div_start_q, div_start_d;
    logic          out_valid_q, out_valid_d;
    logic [3:0]    out_quot_q, out_quot_d;
    logic [3:0]    out_rem_q, out_rem_d;
    logic          out_dbz_q, out_dbz_d;
    logic          in_ready_q, in_ready_d;
    logic          push, pop, empty;
    logic [7:0]    head;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push     = in_valid && in_ready_q;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);

    // in_ready is registered from next-cycle pointers so it is 0 in reset
    assign in_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                          (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        dbz_d       = dbz_q;
        div_start_d = 1'b0;
        out_valid_d = out_valid_q;
        out_quot_d  = out_quot_q;
        out_rem_d   = out_rem_q;
        out_dbz_d   = out_dbz_q;
        pop         = 1'b0;
        unique case (state_q)
            S_IDLE, S_HOLD: begin
                if (state_q == S_IDLE || out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    if (!empty) begin
                        pop     = 1'b1;
                        div_a_d = head[7:4];
                        div_b_d = head[3:0];
                        dbz_d   = (head[3:0] == 4'd0);
                        state_d = S_LOAD;
`ifdef DIV_DBZ_SKIP_EN
                        if (dbz_d) begin
                            state_d     = S_HOLD;
                            out_valid_d = 1'b1;
                            out_quot_d  = 4'hF;
                            out_rem_d   = head[7:4];
                            out_dbz_d   = 1'b1;
                        end
`endif
                    end
                end
            end
            S_LOAD: begin
                div_start_d = 1'b1;
                state_d     = S_FIRE;
            end
            S_FIRE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    out_valid_d = 1'b1;
                    out_quot_d  = dbz_q ? 4'hF : div_result[3:0];
                    out_rem_d   = dbz_q ? div_a_q : div_result[7:4];
                    out_dbz_d   = dbz_q;
                    state_d     = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            dbz_q       <= 1'b0;
            div_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_quot_q  <= '0;
            out_rem_q   <= '0;
            out_dbz_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            dbz_q       <= dbz_d;
            div_start_q <= div_start_d;
            out_valid_q <= out_valid_d;
            out_quot_q  <= out_quot_d;
            out_rem_q   <= out_rem_d;
            out_dbz_q   <= out_dbz_d;
            in_ready_q  <= in_ready_d;
            if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_a, in_b};
        end
    end

    assign in_ready  = in_ready_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign div_start = div_start_q;
    assign out_valid = out_valid_q;
    assign out_quot  = out_quot_q;
    assign out_rem   = out_rem_q;
    assign out_dbz   = out_dbz_q;

endmodule

// File: tb/tb_div_request_sequencer.sv
// Bench for div_request_sequencer: table vectors, corner sequences and
// randomized traffic scored against an arithmetic reference queue.
module tb_div_request_sequencer;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;
    localparam int LAT    = 3 + SETTLE;
`ifdef DIV_DBZ_SKIP_EN
    localparam int DBZ_PULSES = 0;
`else
    localparam int DBZ_PULSES = 1;
`endif

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       d;
    } res_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        res_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [3:0] div_a, div_b;
    logic       div_start;
    logic [7:0] div_result;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_quot, out_rem;
    logic       out_dbz;

    int checks = 0;
    int errors = 0;

    div_request_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .div_a(div_a), .div_b(div_b), .div_start(div_start),
        .div_result(div_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quot(out_quot), .out_rem(out_rem), .out_dbz(out_dbz)
    );

    always #5 clk = ~clk;

    // divider model; a zero divisor yields garbage the DUT must ignore
    always_comb begin
        if (div_b == 4'd0) div_result = 8'hA5;
        else div_result = {div_a % div_b, div_a / div_b};
    end

    function automatic res_t mk(input logic [3:0] q, input logic [3:0] r,
                                input logic d);
        res_t x;
        x.q = q;
        x.r = r;
        x.d = d;
        return x;
    endfunction

    function automatic res_t ref_div(input logic [3:0] a, input logic [3:0] b);
        if (b == 4'd0) return mk(4'hF, a, 1'b1);
        return mk(a / b, a % b, 1'b0);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // passive monitor: records events only, comparisons happen in the test
    int         cyc = 0;
    int         pulses = 0;
    int         hold_viol = 0;
    int         unstable = 0;
    res_t       expq[$];
    res_t       got[$];
    int         got_cyc[$];
    logic [9:0] sb_got[$];
    logic [9:0] sb_exp[$];
    logic       hold_chk = 1'b0;
    res_t       hold_val;
    logic [3:0] prev_a = '0, prev_b = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        prev_a <= div_a;
        prev_b <= div_b;
        if (!rst_n) begin
            expq.delete();
            hold_chk <= 1'b0;
        end else begin
            if (div_start) pulses <= pulses + 1;
            if (div_start && (div_a != prev_a || div_b != prev_b))
                unstable <= unstable + 1;
            if (hold_chk && (!out_valid ||
                mk(out_quot, out_rem, out_dbz) != hold_val))
                hold_viol <= hold_viol + 1;
            if (in_valid && in_ready) expq.push_back(ref_div(in_a, in_b));
            if (out_valid && out_ready) begin
                got.push_back(mk(out_quot, out_rem, out_dbz));
                got_cyc.push_back(cyc);
                sb_got.push_back({1'b0, mk(out_quot, out_rem, out_dbz)});
                if (expq.size() == 0) sb_exp.push_back(10'h200);
                else sb_exp.push_back({1'b0, expq.pop_front()});
            end
            hold_chk <= out_valid && !out_ready;
            hold_val <= mk(out_quot, out_rem, out_dbz);
        end
    end

    int sb_idx = 0;
    task automatic drain_sb();
        while (sb_idx < sb_got.size()) begin
            check($sformatf("scoreboard #%0d", sb_idx),
                  32'(sb_got[sb_idx]), 32'(sb_exp[sb_idx]));
            sb_idx++;
        end
    endtask

    // called and returns just after a falling edge
    task automatic push(input logic [3:0] a, input logic [3:0] b,
                        output int pc);
        int n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        pc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int pc, p0, n;
        string tag;
        tag = $sformatf("%0d/%0d", v.a, v.b);
        p0 = pulses;
        push(v.a, v.b, pc);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " quot"}, 32'(out_quot), 32'(v.exp.q));
        check({tag, " rem"}, 32'(out_rem), 32'(v.exp.r));
        check({tag, " dbz"}, 32'(out_dbz), 32'(v.exp.d));
        if (v.b != 4'd0) check({tag, " latency"}, 32'(cyc - pc), 32'(LAT));
        @(negedge clk);
        check({tag, " valid cleared"}, 32'(out_valid), 32'd0);
        check({tag, " start pulses"}, 32'(pulses - p0),
              32'((v.b == 4'd0) ? DBZ_PULSES : 1));
    endtask

    vec_t tv[9];
    res_t cap_exp[6];

    initial begin
        int pc, g0, n, sent, vhigh;
        bit acc;

        tv[0] = '{4'd13, 4'd3,  mk(4'd4,  4'd1, 1'b0)};
        tv[1] = '{4'd7,  4'd0,  mk(4'hF,  4'd7, 1'b1)};
        tv[2] = '{4'd0,  4'd5,  mk(4'd0,  4'd0, 1'b0)};
        tv[3] = '{4'd15, 4'd4,  mk(4'd3,  4'd3, 1'b0)};
        tv[4] = '{4'd9,  4'd9,  mk(4'd1,  4'd0, 1'b0)};
        tv[5] = '{4'd1,  4'd15, mk(4'd0,  4'd1, 1'b0)};
        tv[6] = '{4'd0,  4'd0,  mk(4'hF,  4'd0, 1'b1)};
        tv[7] = '{4'd14, 4'd5,  mk(4'd2,  4'd4, 1'b0)};
        tv[8] = '{4'd15, 4'd1,  mk(4'd15, 4'd0, 1'b0)};
        cap_exp[0] = mk(4'd15, 4'd0, 1'b0);
        cap_exp[1] = mk(4'd7,  4'd1, 1'b0);
        cap_exp[2] = mk(4'd5,  4'd0, 1'b0);
        cap_exp[3] = mk(4'd3,  4'd3, 1'b0);
        cap_exp[4] = mk(4'd3,  4'd0, 1'b0);
        cap_exp[5] = mk(4'd2,  4'd3, 1'b0);

        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset div_start", 32'(div_start), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset outputs", {out_quot, out_rem, out_dbz, div_a, div_b}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) run_vec(tv[i]);

        // capacity: DEPTH queued plus one in flight
        out_ready = 1'b0;
        g0 = got.size();
        for (int i = 1; i <= DEPTH + 1; i++) push(4'd15, 4'(i), pc);
        check("in_ready full", 32'(in_ready), 32'd0);
        repeat (5) @(negedge clk);
        check("in_ready still full", 32'(in_ready), 32'd0);
        check("result held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        push(4'd15, 4'd6, pc);
        n = 0;
        while (got.size() < g0 + 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check("capacity count", 32'(got.size() - g0), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("capacity order %0d", i), 32'(got[g0 + i]),
                  32'(cap_exp[i]));

        // reset while waiting on the divider
        push(4'd15, 4'd4, pc);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset div_start", 32'(div_start), 32'd0);
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vhigh = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) vhigh++;
        end
        check("no valid after reset", 32'(vhigh), 32'd0);
        check("in_ready after mid reset", 32'(in_ready), 32'd1);

        // back-to-back stream
        g0 = got.size();
        for (int i = 0; i < 8; i++)
            push(4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), pc);
        n = 0;
        while (got.size() < g0 + 8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stream count", 32'(got.size() - g0), 32'd8);
        for (int i = 1; i < 8; i++)
            check($sformatf("stream spacing %0d", i),
                  32'(got_cyc[g0 + i] - got_cyc[g0 + i - 1]), 32'(LAT));

        // randomized traffic with random backpressure
        g0 = got.size();
        sent = 0;
        acc = 1'b0;
        n = 0;
        while (sent < 150 && n < 20000) begin
            if (acc) begin
                in_valid = 1'b0;
                sent++;
            end
            if (!in_valid && sent < 150 && $urandom_range(0, 3) != 0) begin
                in_a = 4'($urandom_range(0, 15));
                in_b = ($urandom_range(0, 7) == 0) ? 4'd0
                                                   : 4'($urandom_range(1, 15));
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            acc = in_valid && in_ready;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("random drained", 32'(expq.size()), 32'd0);
        check("random count", 32'(got.size() - g0), 32'd150);

        drain_sb();
        check("valid held under backpressure", 32'(hold_viol), 32'd0);
        check("operands stable at start", 32'(unstable), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
